// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings, trigger levels and LCR decoding for the UART receive path
package uart_pkg;

  typedef logic [2:0] rxstate_t;

  localparam rxstate_t RX_IDLE   = 3'd0;
  localparam rxstate_t RX_START  = 3'd1;
  localparam rxstate_t RX_DATA   = 3'd2;
  localparam rxstate_t RX_PARITY = 3'd3;
  localparam rxstate_t RX_STOP   = 3'd4;
  localparam rxstate_t RX_BREAK  = 3'd5;

  localparam logic [4:0] TRIG_LVL_1  = 5'd1;
  localparam logic [4:0] TRIG_LVL_4  = 5'd4;
  localparam logic [4:0] TRIG_LVL_8  = 5'd8;
  localparam logic [4:0] TRIG_LVL_14 = 5'd14;

  // Stored entry layout: {break, framing, parity, data[7:0]}
  localparam int ENTRY_W = 11;

  function automatic logic [4:0] trig_level(input logic [1:0] sel);
    case (sel)
      2'b00:   return TRIG_LVL_1;
      2'b01:   return TRIG_LVL_4;
      2'b10:   return TRIG_LVL_8;
      default: return TRIG_LVL_14;
    endcase
  endfunction

  function automatic logic [3:0] word_bits(input logic [1:0] wl);
    return 4'd5 + {2'b00, wl};
  endfunction

endpackage

// File: rtl/uartrxfifo.sv
// rtl/uartrxfifo.sv - RX character buffer with per-entry error tracking
// In single mode the buffer behaves as a one-entry holding register that is overwritten when full.
module uartrxfifo
  import uart_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               single,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               err_any
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      errcnt_q, errcnt_d;
  logic               do_pop, do_push, do_over;
  logic               head_err, in_err;

  assign head_err = |mem_q[rd_ptr_q][ENTRY_W-1:8];
  assign in_err   = |push_data[ENTRY_W-1:8];
  assign full     = single ? (count_q != '0) : (count_q == CW'(DEPTH));
  assign do_pop   = pop && (count_q != '0);
  assign do_push  = push && (!full || do_pop);
  assign do_over  = push && full && !do_pop && single;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    errcnt_d = errcnt_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      errcnt_d = '0;
    end else begin
      if (do_over) begin
        mem_d[rd_ptr_q] = push_data;
      end
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      // An overwrite retires the old head's error and adds the new one's
      errcnt_d = errcnt_q + CW'((do_push || do_over) && in_err)
                          - CW'((do_pop || do_over) && head_err);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      errcnt_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      errcnt_q <= errcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;
  assign err_any = (errcnt_q != '0);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receive datapath: synchronizer, 16x baud sampler, frame FSM and RX buffer
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int  FIFO_DEPTH = 16,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          SIN,
  input  logic [15:0]   Divisor,
  input  logic [1:0]    WordLen,
  input  logic          ParityEn,
  input  logic          EvenParity,
  input  logic          StickParity,
  input  logic          FifoEn,
  input  logic          FifoClr,
  input  logic [1:0]    TrigLvl,
  input  logic          Pop,
  input  logic          ClrOverrun,
  output logic [7:0]    RxData,
  output logic [2:0]    RxErr,
  output logic          DataReady,
  output logic          Overrun,
  output logic          FifoErr,
  output logic          TrigHit,
  output logic [CW-1:0] Count
);

  logic               sync1_q, sync1_d, rxd_q, rxd_d;
  logic [15:0]        baud_q, baud_d, div_eff;
  logic               tick;
  rxstate_t           state_q, state_d;
  logic [3:0]         samp_q, samp_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         data_q, data_d;
  logic               perr_q, perr_d;
  logic               par_bit_q, par_bit_d;
  logic               fifo_en_q, fifo_en_d;
  logic               overrun_q, overrun_d;
  logic [3:0]         nbits;
  logic               exp_par, brk;
  logic               push, clr_any, pop_eff, fifo_full, ov_set;
  logic [ENTRY_W-1:0] push_entry, head;
  logic [4:0]         trig_thr;

  assign sync1_d = SIN;
  assign rxd_d   = sync1_q;
  assign div_eff = (Divisor == 16'd0) ? 16'd1 : Divisor;
  // >= rather than == so a divisor lowered mid-count still wraps promptly
  assign tick    = (baud_q >= div_eff - 16'd1);
  assign baud_d  = tick ? 16'd0 : baud_q + 16'd1;
  assign nbits   = word_bits(WordLen);
  assign exp_par = StickParity ? ~EvenParity : ((^data_q) ^ ~EvenParity);
  assign brk     = !rxd_q && (data_q == 8'h00) && !par_bit_q;

  always_comb begin
    state_d    = state_q;
    samp_d     = tick ? samp_q + 4'd1 : samp_q;
    bitcnt_d   = bitcnt_q;
    data_d     = data_q;
    perr_d     = perr_q;
    par_bit_d  = par_bit_q;
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      RX_IDLE: begin
        if (!rxd_q) begin
          state_d = RX_START;
          samp_d  = 4'd0;
        end
      end
      RX_START: begin
        if (tick && samp_q == 4'd7) begin
          if (rxd_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d   = RX_DATA;
            samp_d    = 4'd0;
            bitcnt_d  = 3'd0;
            data_d    = 8'h00;
            perr_d    = 1'b0;
            par_bit_d = 1'b0;
          end
        end
      end
      RX_DATA: begin
        if (tick && samp_q == 4'd15) begin
          data_d[bitcnt_q] = rxd_q;
          bitcnt_d         = bitcnt_q + 3'd1;
          if ({1'b0, bitcnt_q} == nbits - 4'd1) begin
            state_d = ParityEn ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (tick && samp_q == 4'd15) begin
          par_bit_d = rxd_q;
          perr_d    = (rxd_q != exp_par);
          state_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick && samp_q == 4'd15) begin
          push       = 1'b1;
          push_entry = brk ? {3'b111, 8'h00} : {1'b0, !rxd_q, perr_q, data_q};
          state_d    = brk ? RX_BREAK : RX_IDLE;
        end
      end
      RX_BREAK: begin
        if (rxd_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign fifo_en_d = FifoEn;
  assign clr_any   = FifoClr || (FifoEn != fifo_en_q);
  assign pop_eff   = Pop && DataReady;
  assign ov_set    = push && fifo_full && !pop_eff && !clr_any;
  assign overrun_d = ov_set ? 1'b1 : (ClrOverrun ? 1'b0 : overrun_q);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync1_q   <= 1'b1;
      rxd_q     <= 1'b1;
      baud_q    <= 16'd0;
      state_q   <= RX_IDLE;
      samp_q    <= 4'd0;
      bitcnt_q  <= 3'd0;
      data_q    <= 8'h00;
      perr_q    <= 1'b0;
      par_bit_q <= 1'b0;
      fifo_en_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      rxd_q     <= rxd_d;
      baud_q    <= baud_d;
      state_q   <= state_d;
      samp_q    <= samp_d;
      bitcnt_q  <= bitcnt_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      par_bit_q <= par_bit_d;
      fifo_en_q <= fifo_en_d;
      overrun_q <= overrun_d;
    end
  end

  uartrxfifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (PCLK),
    .rst      (PRESET),
    .clr      (clr_any),
    .single   (!FifoEn),
    .push     (push),
    .push_data(push_entry),
    .pop      (Pop),
    .head     (head),
    .count    (Count),
    .full     (fifo_full),
    .err_any  (FifoErr)
  );

  assign trig_thr  = trig_level(TrigLvl);
  assign RxData    = head[7:0];
  assign RxErr     = head[10:8];
  assign DataReady = (Count != '0);
  assign Overrun   = overrun_q;
  assign TrigHit   = FifoEn ? (32'(Count) >= 32'(trig_thr)) : DataReady;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed scoreboard bench for uart_rx_core
module tb_uart_rx_core;
  import uart_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        SIN = 1'b1;
  logic [15:0] Divisor = 16'd1;
  logic [1:0]  WordLen = 2'b11;
  logic        ParityEn = 1'b0;
  logic        EvenParity = 1'b0;
  logic        StickParity = 1'b0;
  logic        FifoEn = 1'b1;
  logic        FifoClr = 1'b0;
  logic [1:0]  TrigLvl = 2'b00;
  logic        Pop = 1'b0;
  logic        ClrOverrun = 1'b0;
  logic [7:0]  RxData;
  logic [2:0]  RxErr;
  logic        DataReady, Overrun, FifoErr, TrigHit;
  logic [4:0]  Count;

  int compared = 0;
  int mismatched = 0;
  int lat = -1;
  logic [10:0] sb[$];

  uart_rx_core #(.FIFO_DEPTH(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .SIN(SIN), .Divisor(Divisor), .WordLen(WordLen),
    .ParityEn(ParityEn), .EvenParity(EvenParity), .StickParity(StickParity),
    .FifoEn(FifoEn), .FifoClr(FifoClr), .TrigLvl(TrigLvl), .Pop(Pop),
    .ClrOverrun(ClrOverrun), .RxData(RxData), .RxErr(RxErr), .DataReady(DataReady),
    .Overrun(Overrun), .FifoErr(FifoErr), .TrigHit(TrigHit), .Count(Count)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rxdata"}, 32'(RxData), 32'd0);
    check({tag, "_rxerr"}, 32'(RxErr), 32'd0);
    check({tag, "_dready"}, 32'(DataReady), 32'd0);
    check({tag, "_overrun"}, 32'(Overrun), 32'd0);
    check({tag, "_fifoerr"}, 32'(FifoErr), 32'd0);
    check({tag, "_trighit"}, 32'(TrigHit), 32'd0);
    check({tag, "_count"}, 32'(Count), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input logic stop);
    int bt;
    bt = 16 * int'(Divisor);
    SIN = 1'b0;
    cyc(bt);
    for (int i = 0; i < nbits; i++) begin
      SIN = d[i];
      cyc(bt);
    end
    if (pen) begin
      SIN = pbit;
      cyc(bt);
    end
    SIN = stop;
    cyc(bt);
    SIN = 1'b1;
  endtask

  task automatic check_head(input string tag);
    logic [10:0] e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: observed no expected entry expected one queued", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, "_data"}, 32'(RxData), 32'(e[7:0]));
    check({tag, "_err"}, 32'(RxErr), 32'(e[10:8]));
    Pop = 1'b1;
    cyc(1);
    Pop = 1'b0;
  endtask

  initial begin
    cyc(4);
    check_all_zero("reset");
    check("reset_state", 32'(dut.state_q), 32'(RX_IDLE));
    PRESET = 1'b0;
    cyc(4);

    // 8N1 0xA5 at Divisor=1, latency from SIN edge to DataReady
    sb.push_back({3'b000, 8'hA5});
    fork
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
      begin
        for (int i = 1; i <= 300; i++) begin
          cyc(1);
          if (DataReady && lat < 0) lat = i;
        end
      end
    join
    check("a5_latency_window", 32'(lat >= 152 && lat <= 156), 32'd1);
    check_head("a5");
    check("a5_dready_after_pop", 32'(DataReady), 32'd0);

    // 7E1 at Divisor=3: bad parity on 0x41, good parity on 0x43
    Divisor = 16'd3; WordLen = 2'b10; ParityEn = 1'b1; EvenParity = 1'b1;
    cyc(50);
    sb.push_back({3'b001, 8'h41});
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    check("p41_fifoerr", 32'(FifoErr), 32'd1);
    sb.push_back({3'b000, 8'h43});
    send_frame(8'h43, 7, 1'b1, 1'b1, 1'b1);
    check("p43_count", 32'(Count), 32'd2);
    check_head("p41");
    check("p41_fifoerr_after_pop", 32'(FifoErr), 32'd0);
    check_head("p43");
    check("p43_dready_after_pop", 32'(DataReady), 32'd0);

    // Break: line held low well past one frame
    Divisor = 16'd1; WordLen = 2'b11; ParityEn = 1'b0; EvenParity = 1'b0;
    cyc(20);
    sb.push_back({3'b111, 8'h00});
    SIN = 1'b0;
    cyc(16 * 50);
    check("brk_count_low", 32'(Count), 32'd1);
    SIN = 1'b1;
    cyc(32);
    check("brk_count_high", 32'(Count), 32'd1);
    sb.push_back({3'b000, 8'h5A});
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    check("brk_next_count", 32'(Count), 32'd2);
    check_head("brk");
    check_head("brk_next");

    // Start-bit glitch of 5 ticks at Divisor=2
    Divisor = 16'd2;
    cyc(20);
    SIN = 1'b0;
    cyc(10);
    SIN = 1'b1;
    cyc(400);
    check("glitch_count", 32'(Count), 32'd0);
    check("glitch_state", 32'(dut.state_q), 32'(RX_IDLE));

    // Fill the FIFO past full with TrigLvl=4
    Divisor = 16'd1; TrigLvl = 2'b01;
    cyc(20);
    for (int i = 0; i < 17; i++) begin
      int k;
      k = (i + 1 > 16) ? 16 : i + 1;
      if (i < 16) sb.push_back({3'b000, 8'(i)});
      send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1);
      check($sformatf("fill%0d_count", i), 32'(Count), 32'(k));
      check($sformatf("fill%0d_trighit", i), 32'(TrigHit), 32'(k >= 4));
      if (i == 15) check("fill_overrun_at_full", 32'(Overrun), 32'd0);
    end
    check("fill_overrun", 32'(Overrun), 32'd1);
    ClrOverrun = 1'b1;
    cyc(1);
    ClrOverrun = 1'b0;
    check("fill_overrun_cleared", 32'(Overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check_head($sformatf("drain%0d", i));
    end
    check("drain_count", 32'(Count), 32'd0);

    // Holding-register mode: overwrite sets Overrun, then reset mid-frame
    FifoEn = 1'b0;
    cyc(5);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    check("hold_rxdata", 32'(RxData), 32'h22);
    check("hold_overrun", 32'(Overrun), 32'd1);
    check("hold_count", 32'(Count), 32'd1);
    check("hold_trighit", 32'(TrigHit), 32'd1);
    SIN = 1'b0;
    cyc(16);
    SIN = 1'b1;
    cyc(16);
    SIN = 1'b0;
    cyc(40);
    PRESET = 1'b1;
    SIN = 1'b1;
    cyc(3);
    PRESET = 1'b0;
    cyc(300);
    check_all_zero("midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Receive datapath for the PC16550D-compatible UART: synchronizes and oversamples the serial input and recovers 5–8-bit characters with optional parity. It buffers received characters with per-character error flags in an RX FIFO and produces the LSR receive-status bits and the data-available trigger. It sits beside the register file in the UART and is driven by its DLL/DLM, LCR and FCR fields. The register file pops it on RBR reads.

## Interface
- FIFO_DEPTH, 16, RX FIFO entries; power of 2, ≥2
- PCLK  in  1  UART clock
- PRESET  in  1  synchronous, active-high reset
- SIN  in  1  asynchronous serial input, idle high
- Divisor  in  16  {DLM,DLL}; one 16x sample tick every Divisor PCLK cycles; 0 is treated as 1
- WordLen  in  2  LCR[1:0]: 00=5, 01=6, 10=7, 11=8 data bits
- ParityEn, EvenParity, StickParity  in  1 each  LCR[3], LCR[4], LCR[5]
- FifoEn  in  1  FCR[0]; 0 = single holding register (depth 1)
- FifoClr  in  1  one-cycle pulse, empties the FIFO
- TrigLvl  in  2  FCR[7:6]: 00=1, 01=4, 10=8, 11=14 entries
- Pop  in  1  RBR read strobe; removes the head entry
- ClrOverrun  in  1  LSR read strobe; clears Overrun
- RxData  out  8  head entry data, zero-extended; 0 when empty
- RxErr  out  3  head entry {break, framing, parity}; 0 when empty
- DataReady  out  1  FIFO non-empty (LSR[0])
- Overrun  out  1  sticky overrun (LSR[1])
- FifoErr  out  1  any stored entry has a non-zero RxErr (LSR[7])
- TrigHit  out  1  Count ≥ trigger level (FifoEn=1); DataReady when FifoEn=0
- Count  out  $clog2(FIFO_DEPTH)+1  entries held

## Operation
- SIN passes through a 2-flop synchronizer. All FSM decisions use the synchronized value rxd.
- Baud counter counts PCLK cycles 1..Divisor and pulses tick when it wraps. It runs continuously.
- The sample counter is 4 bits and advances on tick.
- FSM states: RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK.
  - RX_IDLE: when rxd=0, clear the sample counter and go to RX_START.
  - RX_START: on the 8th tick, sample rxd. If rxd=1, it was a glitch; go to RX_IDLE. Otherwise clear the counter and bit count, and go to RX_DATA.
  - RX_DATA: on every 16th tick, shift rxd in LSB-first. After WordLen+5 bits, go to RX_PARITY if ParityEn=1, else RX_STOP.
  - RX_PARITY: on the 16th tick, sample the parity bit.
    - Expected parity: StickParity=1 gives ~EvenParity.
    - Otherwise it is XOR(data) ^ ~EvenParity.
    - A mismatch sets parity error.
  - RX_STOP: on the 16th tick, sample the stop bit.
    - rxd=0 sets framing error.
    - If data, parity and stop are all 0, set break and force data to 0x00.
    - Push the entry, then go to RX_BREAK if break is set, else RX_IDLE.
  - RX_BREAK: wait for rxd=1, then go to RX_IDLE. Exactly one entry is pushed per break.
- Only the first stop bit is checked; LCR[2] is ignored on receive.
- Push into a full buffer:
  - FifoEn=1: the new character is discarded.
  - FifoEn=0: the holding register is overwritten.
  - In both cases Overrun is set.
- Push and Pop in the same cycle with the buffer full: both are accepted; no overrun.
- Pop when empty is ignored.
- FifoClr with a push in the same cycle: clear wins and the push is dropped, without setting Overrun. FifoClr does not reset the FSM or Overrun.
- ClrOverrun together with a new overrun: Overrun stays 1 (set wins).
- A FifoEn transition empties the FIFO.

## Timing
- Reset values: all outputs 0; FSM in RX_IDLE; counters 0.
- Reset mid-frame aborts the character; no entry is pushed.
- Latency, SIN falling edge to push: 2 PCLK (synchronizer) plus (8 + 16·(bits + parity + 1)) ticks.
- Pushed entry is visible on DataReady/RxData/Count in the PCLK cycle after the push.
- Pop: the next entry appears the cycle after the Pop.
- RxData/RxErr are combinational from the head entry.
- FifoErr and TrigHit are registered-state functions valid the same cycle as Count.
- A new start bit is detected no earlier than the cycle after RX_STOP exits, so back-to-back frames with a single stop bit are received.

## Structure
- uart_pkg holds:
  - the rxstate enum;
  - the trigger-level constants (1/4/8/14);
  - WordLen decoding.
- Sub-module uartrxfifo (parameter DEPTH, entry width 11 = data + 3 flags).
  - Contains head/tail pointers and Count.
  - Provides a per-entry error-count used for FifoErr.
- The baud counter, synchronizer and FSM live in uart_rx_core.

## Test plan
- Divisor=1, 8N1, frame 0xA5: DataReady rises 2 + 8 + 144 = 154 cycles (±2) after the SIN edge; RxData=0xA5; RxErr=0.
- Divisor=3, 7E1, data 0x41, bad parity bit: RxData=0x41, RxErr=001, FifoErr=1. Pop: FifoErr=0, DataReady=0.
- 8N1, stop bit 0 then SIN held low for 40 bit times: exactly one entry with 0x00 and RxErr=111; none further until SIN returns high and a new frame arrives.
- SIN low pulse of 5 ticks at Divisor=2: no entry; FSM back to RX_IDLE; Count=0.
- FifoEn=1, TrigLvl=01, 17 frames 0x00..0x10 with no Pop:
  - TrigHit rises at Count=4;
  - Count=16 and Overrun=1 after frame 0x10;
  - head=0x00, tail entry=0x0F.
  - ClrOverrun clears Overrun.
- FifoEn=0, two frames 0x11, 0x22 with no Pop: RxData=0x22, Overrun=1. Assert PRESET mid third frame: all outputs 0 and no entry pushed.
